uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 tb/tb_uart_rx_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART peripheral parameters: receive FIFO defaults and sizing helpers.
package uart_rx_fifo_pkg;

    localparam int UART_RX_DEPTH          = 4;
    localparam int UART_RX_WIDTH          = 8;
    localparam int UART_RX_THRESHOLD      = 2;
    localparam int UART_RX_TIMEOUT_CYCLES = 4096;

    // Per-cycle FIFO operation, encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        FIFO_IDLE  = 2'b00,
        FIFO_RD    = 2'b01,
        FIFO_WR    = 2'b10,
        FIFO_WR_RD = 2'b11
    } fifo_op_e;

    // Width of a fill-level counter that must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous show-ahead FIFO; power-of-two depth so pointers wrap naturally.
module uart_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH = UART_RX_DEPTH,
    parameter  int WIDTH = UART_RX_WIDTH,
    localparam int CW    = count_w(DEPTH),
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             wr_ok;
    logic             rd_ok;
    fifo_op_e         op;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign op      = fifo_op_e'({wr_ok, rd_ok});
    assign rd_data = mem[rd_ptr];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            case (op)
                FIFO_WR: cnt_q <= cnt_q + CW'(1);
                FIFO_RD: cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is data only; held bytes are discarded by the pointer reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: accepts bytes from the receiver, raises irq on fill level or idle timeout.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH          = UART_RX_DEPTH,
    parameter  int WIDTH          = UART_RX_WIDTH,
    parameter  int THRESHOLD      = UART_RX_THRESHOLD,
    parameter  int TIMEOUT_CYCLES = UART_RX_TIMEOUT_CYCLES,
    localparam int CW             = count_w(DEPTH),
    localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_read,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             timeout,
    output logic             irq
);

    logic          rd_ok;
    logic [TW-1:0] idle_q;
    logic [TW-1:0] idle_d;
    logic          timeout_q;
    logic          timeout_d;
    logic          irq_q;

    // Acknowledge depends only on registered fill state, so a byte is never taken twice.
    assign rx_read = rx_valid & ~full & ~rst;
    assign rd_ok   = rd_en & ~empty;
    assign timeout = timeout_q;
    assign irq     = irq_q;

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_read),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (rx_read || rd_ok || empty)
            idle_d = '0;
        else if (idle_q != TW'(TIMEOUT_CYCLES - 1))
            idle_d = idle_q + TW'(1);
        // A write restarts the idle count but leaves an already-raised flag alone.
        if (rd_ok || empty)
            timeout_d = 1'b0;
        else if (idle_d == TW'(TIMEOUT_CYCLES - 1))
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            irq_q     <= (count >= CW'(THRESHOLD)) | timeout_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int THR   = 2;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_read;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       timeout;
    logic       irq;

    uart_rx_fifo #(
        .DEPTH          (DEPTH),
        .WIDTH          (WIDTH),
        .THRESHOLD      (THR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_read  (rx_read),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .timeout  (timeout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;
    logic [7:0] m_q[$];
    int         m_idle = 0;
    bit         m_tmo = 1'b0;
    bit         m_irq = 1'b0;
    bit         m_acc_w = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, idle streak as a plain cycle count.
    always @(posedge clk) begin
        bit acc_r;
        int sz;
        sz      = m_q.size();
        m_acc_w = 1'b0;
        acc_r   = 1'b0;
        if (rst) begin
            m_q.delete();
            m_idle = 0;
            m_tmo  = 1'b0;
            m_irq  = 1'b0;
        end else begin
            m_acc_w = rx_valid && (sz < DEPTH);
            acc_r   = rd_en && (sz > 0);
            m_irq   = (sz >= THR) || m_tmo;
            if (acc_r || sz == 0) m_tmo = 1'b0;
            if (m_acc_w || acc_r || sz == 0) begin
                m_idle = 0;
            end else begin
                if (m_idle < TMO - 1) m_idle++;
                if (m_idle == TMO - 1) m_tmo = 1'b1;
            end
            if (acc_r) void'(m_q.pop_front());
            if (m_acc_w) m_q.push_back(rx_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_read", rx_read, rx_valid && (m_q.size() < DEPTH) && !rst);
            chk("count", count, m_q.size());
            chk("empty", empty, m_q.size() == 0);
            chk("full", full, m_q.size() == DEPTH);
            chk("timeout", timeout, m_tmo);
            chk("irq", irq, m_irq);
            if (m_q.size() > 0) chk("rd_data", rd_data, m_q[0]);
        end
    end

    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        rd_en    = r;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e2 [4];
        logic [7:0] e4 [4];
        int wp [4];
        int rp [4];
        e2 = '{8'h02, 8'h03, 8'h04, 8'h05};
        e4 = '{8'hA3, 8'hA4, 8'hA5, 8'hA6};
        wp = '{70, 20, 50, 6};
        rp = '{20, 70, 50, 3};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_irq", irq, 0);

        // First byte after reset
        cycle(1'b1, 8'h5A, 1'b0);
        chk("first_rx_read", rx_read, 1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("first_count", count, 1);
        chk("first_empty", empty, 0);
        chk("first_rd_data", rd_data, 8'h5A);
        chk("first_rx_read_low", rx_read, 0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("first_drained", empty, 1);

        // Fill to full, back-pressure, read frees a slot for the held byte
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h04, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        chk("full_flag", full, 1);
        chk("full_block", rx_read, 0);
        cycle(1'b1, 8'h05, 1'b1);
        chk("full_head", rd_data, 8'h01);
        chk("full_read_only", rx_read, 0);
        cycle(1'b1, 8'h05, 1'b0);
        chk("after_read_count", count, 3);
        chk("after_read_ack", rx_read, 1);
        chk("after_read_head", rd_data, 8'h02);
        cycle(1'b0, 8'h00, 1'b0);
        chk("held_byte_in", count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("drain1_order", rd_data, e2[k]);
            cycle(1'b0, 8'h00, 1'b1);
            cycle(1'b0, 8'h00, 1'b0);
        end
        chk("drain1_empty", empty, 1);

        // Empty with simultaneous read and write: write only
        cycle(1'b1, 8'hA5, 1'b1);
        chk("empty_wr_ack", rx_read, 1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("empty_wr_count", count, 1);
        chk("empty_wr_data", rd_data, 8'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("empty_rd_count", count, 0);
        chk("empty_rd_empty", empty, 1);

        // Simultaneous read+write at count=2, then pointer wrap after six writes
        do_reset();
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b1);
        chk("rw_pre_count", count, 2);
        cycle(1'b1, 8'hA4, 1'b0);
        chk("rw_count_kept", count, 2);
        chk("rw_head", rd_data, 8'hA2);
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hA6, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("wrap_full", full, 1);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_order", rd_data, e4[k]);
            cycle(1'b0, 8'h00, 1'b1);
            cycle(1'b0, 8'h00, 1'b0);
        end

        // Idle timeout with a single byte pending
        do_reset();
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 14; k++) cycle(1'b0, 8'h00, 1'b0);
        chk("tmo_not_yet", timeout, 0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("tmo_set", timeout, 1);
        chk("tmo_irq_lag", irq, 0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("tmo_irq", irq, 1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("tmo_clear", timeout, 0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("tmo_irq_clear", irq, 0);

        // Reset mid-operation with a pending byte
        do_reset();
        cycle(1'b1, 8'hB1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_irq", irq, 1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_ack", rx_read, 0);
        cycle(1'b1, 8'h77, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_irq", irq, 0);
        chk("midrst_ack", rx_read, 1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("midrst_accept", count, 1);
        chk("midrst_data", rd_data, 8'h77);

        // Randomized traffic against the model
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 700; i++) begin
                @(posedge clk);
                #1;
                rst = ($urandom_range(0, 599) == 0);
                if (rx_valid && m_acc_w) rx_valid = 1'b0;
                if (!rx_valid && ($urandom_range(0, 99) < wp[ph])) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'($urandom);
                end
                rd_en = ($urandom_range(0, 99) < rp[ph]);
            end
        end
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
